// File: rtl/band_scale_seq.sv
// Five-band gain stage: each band's pot is squared into a gain, multiplied
// with that band's audio sample and saturated; one squarer and one multiplier serve all bands in turn.
module band_scale_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        smpl_vld,
  input  logic [59:0] pot_bus,
  input  logic [79:0] aud_bus,
  output logic [79:0] scaled_bus,
  output logic        scaled_vld,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    MUL  = 3'd2,
    SAT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BAND = 3'd4;

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         bidx_q;
  logic [11:0]        pot_q [5];
  logic [15:0]        aud_q [5];
  logic [15:0]        res_q [5];
  logic [11:0]        gain_q;
  logic signed [28:0] prod_q;

  logic [11:0]        pot_sel;
  logic [15:0]        aud_sel;
  logic [23:0]        sqr_full;
  logic signed [28:0] mul_full;
  logic [15:0]        sat_val;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pot_sel = '0;
    aud_sel = '0;
    for (int i = 0; i < 5; i++) begin
      if (bidx_q == 3'(i)) begin
        pot_sel = pot_q[i];
        aud_sel = aud_q[i];
      end
    end
  end

  // Shared arithmetic: 12x12 unsigned squarer and 13x16 signed multiplier.
  assign sqr_full = pot_sel * pot_sel;
  assign mul_full = $signed({1'b0, gain_q}) * $signed(aud_sel);

  // Bits [28:25] must all agree for the Q10 slice [25:10] to be exact.
  always_comb begin
    if (!prod_q[28] && (prod_q[27:25] != 3'b000)) begin
      sat_val = 16'h7FFF;
    end else if (prod_q[28] && (prod_q[27:25] != 3'b111)) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = prod_q[25:10];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (smpl_vld) state_d = SQR;
      SQR:     state_d = MUL;
      MUL:     state_d = SAT;
      SAT:     state_d = (bidx_q == LAST_BAND) ? DONE : SQR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bidx_q     <= '0;
      gain_q     <= '0;
      prod_q     <= '0;
      scaled_bus <= '0;
      ovr        <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (smpl_vld) begin
            bidx_q <= '0;
          end
        end
        SQR: gain_q <= sqr_full[23:12];
        MUL: prod_q <= mul_full;
        SAT: begin
          for (int i = 0; i < 5; i++) begin
            if (bidx_q == 3'(i)) res_q[i] <= sat_val;
          end
          // Whole set loads as the FSM enters DONE, so it is on the bus
          // during the scaled_vld cycle; band 4 is forwarded from sat_val.
          if (bidx_q == LAST_BAND) begin
            scaled_bus <= {sat_val, res_q[3], res_q[2], res_q[1], res_q[0]};
          end else begin
            bidx_q <= bidx_q + 3'd1;
          end
        end
        default: ;
      endcase
      if (smpl_vld && (state_q != IDLE)) begin
        ovr <= 1'b1;
      end
    end
  end

  // NOTE: the capture registers carry no reset; they are always written
  // before use, and leaving them out of the reset saves routing on wide buses.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == IDLE) && smpl_vld) begin
      for (int i = 0; i < 5; i++) begin
        pot_q[i] <= pot_bus[12*i +: 12];
        aud_q[i] <= aud_bus[16*i +: 16];
      end
    end
  end

  assign scaled_vld = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule
